// File: rtl/ser_tx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ser_tx_pkg
// Shared definitions for the ser_tx_ctrl word serializer:
//   - state_e     : controller states (idle, shifting a word, inter-word gap)
//   - DEF_*       : default values for the W, GAP and IDLE_BIT parameters
//   - cnt_width() : counter width helper, never returns less than 1 bit so
//                   a degenerate counter (e.g. GAP=0) still has a legal width
// ---------------------------------------------------------------------------
package ser_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int   DEF_W        = 4;
    localparam int   DEF_GAP      = 1;
    localparam logic DEF_IDLE_BIT = 1'b0;

    // clog2 of n, clamped to a minimum of one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ser_tx_ctrl.sv
// ---------------------------------------------------------------------------
// ser_tx_ctrl
// Serializes parallel words into a W-bit bidirectional shift register that
// has no enable. Each accepted word is sent over W cycles on d, with R_L
// chosen so the word lands bit-aligned in the downstream q[W-1:0]; par_valid
// pulses for one cycle when q holds the complete word.
//
// Ports:
//   clk        in   rising-edge clock, shared with the downstream register
//   rst        in   synchronous active-high reset
//   in_data    in   [W-1:0] word to send (bit i ends in downstream q_i)
//   in_dir     in   direction for this word, copied to R_L
//   in_valid   in   in_data/in_dir valid
//   in_ready   out  combinational: a word can be accepted this cycle
//   d          out  registered serial bit (IDLE_BIT when no word bit)
//   R_L        out  registered direction select (1 = shift toward q0)
//   par_valid  out  registered one-cycle strobe: downstream q is complete
//   busy       out  registered, high while shifting or in the gap
// ---------------------------------------------------------------------------
module ser_tx_ctrl
    import ser_tx_pkg::*;
#(
    parameter int   W        = DEF_W,
    parameter int   GAP      = DEF_GAP,
    parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_dir,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         d,
    output logic         R_L,
    output logic         par_valid,
    output logic         busy
);

    localparam int KW = cnt_width(W);
    localparam int GW = cnt_width(GAP + 1);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);
    localparam logic [GW-1:0] G_LAST = (GAP > 0) ? GW'(GAP - 1) : {GW{1'b0}};

    state_e        state_r, state_s;
    logic [KW-1:0] k_r, k_s;
    logic [GW-1:0] g_r, g_s;
    logic [W-1:0]  shadow_r, shadow_s;
    logic          dir_s;
    logic          d_s;
    logic          pv_s;
    logic          accept_s;

    // Bit k of a word in transmit order: LSB first toward q0, MSB first otherwise
    function automatic logic pick_bit(input logic [W-1:0] word,
                                      input logic         dir,
                                      input logic [KW-1:0] k);
        logic [KW-1:0] idx;
        idx = dir ? k : (K_LAST - k);
        return word[idx];
    endfunction

    // Ready decode: idle, last shift bit when there is no gap, or last gap cycle
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready = 1'b1;
            ST_SHIFT: in_ready = (GAP == 0) && (k_r == K_LAST);
            ST_GAP:   in_ready = (g_r == G_LAST);
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept_s = in_valid && in_ready;

    // Next-state, counters and next values of the registered outputs
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        g_s      = g_r;
        shadow_s = shadow_r;
        dir_s    = R_L;
        d_s      = IDLE_BIT;
        pv_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                // last bit shifts in at the end of this cycle, so q is full next cycle
                pv_s = (k_r == K_LAST);
                if (k_r != K_LAST) begin
                    k_s = k_r + 1'b1;
                    d_s = pick_bit(shadow_r, R_L, k_r + 1'b1);
                end else if (GAP > 0) begin
                    state_s = ST_GAP;
                    k_s     = {KW{1'b0}};
                    g_s     = {GW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                    k_s     = {KW{1'b0}};
                end
            end
            ST_GAP: begin
                if (g_r == G_LAST) begin
                    state_s = ST_IDLE;
                    g_s     = {GW{1'b0}};
                end else begin
                    g_s = g_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                k_s     = {KW{1'b0}};
                g_s     = {GW{1'b0}};
            end
        endcase
        // An accept only happens in ready states; it always starts a new word
        if (accept_s) begin
            state_s  = ST_SHIFT;
            k_s      = {KW{1'b0}};
            g_s      = {GW{1'b0}};
            shadow_s = in_data;
            dir_s    = in_dir;
            d_s      = pick_bit(in_data, in_dir, {KW{1'b0}});
        end else begin
            shadow_s = shadow_s;
        end
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            k_r       <= {KW{1'b0}};
            g_r       <= {GW{1'b0}};
            shadow_r  <= {W{1'b0}};
            d         <= IDLE_BIT;
            R_L       <= 1'b0;
            par_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            k_r       <= k_s;
            g_r       <= g_s;
            shadow_r  <= shadow_s;
            d         <= d_s;
            R_L       <= dir_s;
            par_valid <= pv_s;
            busy      <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ser_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ser_tx_ctrl
// Directed bench for ser_tx_ctrl. Three instances (GAP=1, GAP=0, GAP=2) share
// the stimulus; each phase resets all of them and checks one instance. A
// model of the downstream 4-bit bidirectional shift register is attached to
// each instance so the landed word can be checked when par_valid pulses.
// ---------------------------------------------------------------------------
module tb_ser_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data = 4'd0;
    logic       in_dir = 1'b0;
    logic       in_valid = 1'b0;

    logic ya, da, ra, pa, ba;
    logic yb, db, rb, pb, bb;
    logic yc, dc, rc, pc, bc;

    logic [3:0] qa = 4'd0;
    logic [3:0] qb = 4'd0;
    logic [3:0] qc = 4'd0;

    int checks = 0;
    int errors = 0;

    bit [0:15] ed, er, ep, ey, eb;

    always #5 clk = ~clk;

    ser_tx_ctrl #(.W(4), .GAP(1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
        .in_ready(ya), .d(da), .R_L(ra), .par_valid(pa), .busy(ba));

    ser_tx_ctrl #(.W(4), .GAP(0), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
        .in_ready(yb), .d(db), .R_L(rb), .par_valid(pb), .busy(bb));

    ser_tx_ctrl #(.W(4), .GAP(2), .IDLE_BIT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
        .in_ready(yc), .d(dc), .R_L(rc), .par_valid(pc), .busy(bc));

    // Downstream registers: R_L=1 shifts toward q0 with d entering q3
    always @(posedge clk) begin
        qa <= ra ? {da, qa[3:1]} : {qa[2:0], da};
        qb <= rb ? {db, qb[3:1]} : {qb[2:0], db};
        qc <= rc ? {dc, qc[3:1]} : {qc[2:0], dc};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        // ---------------- reset state and 20 idle cycles (GAP=1) ----------
        do_reset();
        @(negedge clk);
        chk("rst d", da, 1'b0);
        chk("rst R_L", ra, 1'b0);
        chk("rst par_valid", pa, 1'b0);
        chk("rst busy", ba, 1'b0);
        chk("rst in_ready", ya, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("idle d[%0d]", i), da, 1'b0);
            chk($sformatf("idle ready[%0d]", i), ya, 1'b1);
            chk($sformatf("idle busy[%0d]", i), ba, 1'b0);
            chk($sformatf("idle pv[%0d]", i), pa, 1'b0);
        end

        // ---------------- word 1011 LSB first, GAP=1 ----------------------
        tick();
        in_data = 4'b1011; in_dir = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("A1 accept ready", ya, 1'b1);
        ed = 16'b1101_0000_0000_0000;
        er = 16'b1111_1100_0000_0000;
        ep = 16'b0000_1000_0000_0000;
        eb = 16'b1111_1000_0000_0000;
        ey = 16'b0000_1100_0000_0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            in_valid = 1'b0; in_data = 4'b0000; in_dir = 1'b0;
            @(negedge clk);
            chk($sformatf("A1 d[%0d]", i), da, ed[i]);
            chk($sformatf("A1 R_L[%0d]", i), ra, er[i]);
            chk($sformatf("A1 pv[%0d]", i), pa, ep[i]);
            chk($sformatf("A1 busy[%0d]", i), ba, eb[i]);
            chk($sformatf("A1 ready[%0d]", i), ya, ey[i]);
            if (i == 4) chk("A1 q", qa, 4'b1011);
        end

        // ---------------- word 1000 MSB first, GAP=1 ----------------------
        tick();
        in_data = 4'b1000; in_dir = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("A2 accept ready", ya, 1'b1);
        ed = 16'b1000_0000_0000_0000;
        er = 16'b0000_0000_0000_0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            in_valid = 1'b0; in_data = 4'b1111; in_dir = 1'b1;
            @(negedge clk);
            chk($sformatf("A2 d[%0d]", i), da, ed[i]);
            chk($sformatf("A2 R_L[%0d]", i), ra, er[i]);
            chk($sformatf("A2 pv[%0d]", i), pa, ep[i]);
            chk($sformatf("A2 busy[%0d]", i), ba, eb[i]);
            chk($sformatf("A2 ready[%0d]", i), ya, ey[i]);
            if (i == 4) chk("A2 q", qa, 4'b1000);
        end

        // ---------------- reset at SHIFT k=2 (GAP=1) ----------------------
        tick();
        in_data = 4'b1111; in_dir = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("R k0 d", da, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("R k2 d", da, 1'b1);
        chk("R k2 busy", ba, 1'b1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("R after d", da, 1'b0);
        chk("R after R_L", ra, 1'b0);
        chk("R after ready", ya, 1'b1);
        chk("R after busy", ba, 1'b0);
        chk("R after pv", pa, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("R no pv[%0d]", i), pa, 1'b0);
            chk($sformatf("R idle d[%0d]", i), da, 1'b0);
        end

        // ---------------- GAP=0 back-to-back words -------------------------
        do_reset();
        in_data = 4'b0110; in_dir = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("B accept ready", yb, 1'b1);
        tick();
        in_data = 4'b1001; in_dir = 1'b0;
        ed = 16'b0110_1001_0000_0000;
        er = 16'b1111_0000_0000_0000;
        ep = 16'b0000_1000_1000_0000;
        ey = 16'b0001_0001_1000_0000;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                in_valid = 1'b0; in_data = 4'b0000; in_dir = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("B d[%0d]", i), db, ed[i]);
            chk($sformatf("B R_L[%0d]", i), rb, er[i]);
            chk($sformatf("B pv[%0d]", i), pb, ep[i]);
            chk($sformatf("B ready[%0d]", i), yb, ey[i]);
            if (i == 4) chk("B q0", qb, 4'b0110);
            if (i == 8) chk("B q1", qb, 4'b1001);
            tick();
        end

        // ---------------- GAP=2, in_valid held high ------------------------
        do_reset();
        in_data = 4'b1111; in_dir = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("C accept ready", yc, 1'b1);
        ed = 16'b1111_0011_1100_0000;
        ep = 16'b0000_1000_0010_0000;
        ey = 16'b0000_0100_0000_0000;
        for (int i = 0; i < 11; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("C d[%0d]", i), dc, ed[i]);
            chk($sformatf("C pv[%0d]", i), pc, ep[i]);
            chk($sformatf("C ready[%0d]", i), yc, ey[i]);
            chk($sformatf("C busy[%0d]", i), bc, 1'b1);
            chk($sformatf("C R_L[%0d]", i), rc, 1'b1);
            if (i == 4 || i == 10) chk($sformatf("C q[%0d]", i), qc, 4'b1111);
        end
        in_valid = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_tx_ctrl.md
Name: ser_tx_ctrl

Overview:
Upstream word serializer for the 4-bit bidirectional shift register (serial input d, direction select R_L, free-running clk). It accepts parallel words over a valid/ready handshake and drives d and R_L so that each word lands bit-aligned in q[W-1:0]. A one-cycle strobe marks the cycle in which the downstream register holds the complete word. The downstream register has no enable, so this block drives d on every cycle, including idle cycles.

Parameters:
W, 4, word width; equals the downstream register length.
GAP, 1, number of idle cycles inserted after each word (0 allows back-to-back words).
IDLE_BIT, 0, value driven on d when no word bit is being sent.

Ports:
clk  in  1  rising-edge clock, shared with the downstream register.
rst  in  1  synchronous reset, active-high.
in_data  in  W  word to send; bit i must land in downstream q_i.
in_dir  in  1  direction for this word; copied to R_L (1 = shift toward q0, serial bit enters q[W-1]).
in_valid  in  1  in_data/in_dir valid.
in_ready  out  1  block can accept a word this cycle.
d  out  1  serial bit to the downstream register.
R_L  out  1  direction select to the downstream register.
par_valid  out  1  one-cycle strobe: downstream q holds the full accepted word this cycle.
busy  out  1  high while in SHIFT or GAP.

Behaviour:
- All outputs are registered except in_ready, which is a combinational decode of state and counter.
- Reset (synchronous): state=IDLE, d=IDLE_BIT, R_L=0, par_valid=0, busy=0, counters=0, shadow=0.
- Reset mid-word: the word is aborted, no par_valid is issued, and the next cycle is IDLE.
- Accept: a word is accepted on any cycle where in_valid && in_ready. The block latches in_data into a shadow register and in_dir into R_L.
- States and transitions:
  - IDLE: in_ready=1, d=IDLE_BIT, R_L holds its last value. An accept moves to SHIFT with bit counter k=0.
  - SHIFT: runs for W cycles, k=0..W-1, with d = selected bit k.
    - in_dir=1: send LSB first, so d = in_data[k].
    - in_dir=0: send MSB first, so d = in_data[W-1-k].
    - At k=W-1: go to GAP if GAP>0. Otherwise go to SHIFT (k=0) on a new accept, or to IDLE if there is none.
  - GAP: runs for GAP cycles with d=IDLE_BIT and R_L held. On the last GAP cycle, go to SHIFT on an accept, else to IDLE.
- in_ready is high in IDLE, on SHIFT k=W-1 when GAP=0, and on the last GAP cycle. This gives zero bubble between frames.
- Latency: acceptance in cycle t puts bit 0 on d in cycle t+1. The downstream register captures bit k at the end of cycle t+1+k. par_valid=1 in cycle t+1+W, exactly one cycle.
- R_L is constant for all W bits of a word and changes only on an accept.
- busy=1 in SHIFT and GAP.
- in_data and in_dir are ignored when not accepted. in_valid may drop at any time without effect.
- Widths: the bit counter is clog2(W) bits and the gap counter is clog2(GAP+1) bits. Neither counter wraps beyond its terminal value.

Decomposition:
- Package ser_tx_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - the counter-width helper function;
  - the defaults for W, GAP and IDLE_BIT.
- No sub-module is needed. The optional internal bit-select mux stays inline.

Test Plan:
- W=4, GAP=1, accept in_data=4'b1011, in_dir=1 -> d=1,1,0,1 in cycles t+1..t+4; R_L=1 throughout; par_valid only in cycle t+5; downstream q3..q0=1011 in that cycle.
- Accept 4'b1000, in_dir=0 -> d=1,0,0,0; R_L=0; par_valid at t+5; q=1000.
- GAP=0, in_valid held high with words 4'b0110 (dir 1) then 4'b1001 (dir 0):
  - d streams 0,1,1,0,1,0,0,1 with no bubble;
  - R_L switches at the word boundary;
  - par_valid at t+5 (q=0110) and t+9 (q=1001).
- rst asserted at SHIFT k=2 -> next cycle: IDLE, d=0, R_L=0, par_valid never pulses for that word, in_ready=1.
- in_valid low for 20 cycles after reset -> d=IDLE_BIT, in_ready=1, busy=0, par_valid=0 throughout.
- GAP=2, in_valid held high -> in_ready high only in IDLE and on the last GAP cycle; exactly 2 idle bits on d between words.
